timestamp_capture: RTL
======================

# timestamp_capture

Multi-channel event timestamper: a free-running pWIDTH-bit counter is sampled on selectable edges of up to pCHANNELS asynchronous event inputs. Each capture is queued with its edge type in a per-channel FIFO of depth pDEPTH. The block sits between the external detector/latch lines and the host readout logic. It replaces single-shot latch/ready pairs with synchronised, queued, overflow-checked capture.

## Interface
Parameters:
- pWIDTH, 40: counter and timestamp width.
- pCHANNELS, 4: number of event channels (1..16).
- pDEPTH, 4: entries per channel FIFO; must be a power of 2, at least 2.

Ports:
- iCLK  in  1  single clock; all logic on its rising edge.
- iRST_N  in  1  reset, asynchronous assert, active-low (fixed polarity and synchronicity).
- iEvent  in  pCHANNELS  asynchronous event lines.
- iEdgeSel  in  2*pCHANNELS  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
- iClear  in  1  synchronous clear of counter, FIFOs and overflow flags.
- iRdCh  in  max(1,$clog2(pCHANNELS))  channel selected for readout.
- iRdEn  in  1  pop the head entry of channel iRdCh.
- oTimestamp  out  pWIDTH  head timestamp of iRdCh; 0 when that FIFO is empty.
- oEdge  out  1  head edge type of iRdCh (1 rising, 0 falling); 0 when empty.
- oValid  out  pCHANNELS  per-channel FIFO non-empty.
- oOverflow  out  pCHANNELS  per-channel sticky drop flag.
- oCounter  out  pWIDTH  live counter value.
- oWrap  out  1  one-cycle pulse when the counter wraps.

## Operation
- Counter: increments every cycle. It wraps from all-ones to 0, and the cycle showing 0 has oWrap=1. iClear forces it to 0 with no oWrap pulse.
- Per channel: 3-flop chain s1→s2→s3 on iEvent[c]. Rise = s2&~s3, fall = ~s2&s3. An event fires when the detected edge is enabled by iEdgeSel[c].
- Arming: the detectors are disarmed for the first 3 cycles after iRST_N release, so a line held high at reset does not create an event.
- Capture: a fired event writes {edge type, oCounter} into FIFO c. Channels are independent; simultaneous events on several channels all capture the same timestamp.
- Full FIFO: a new event is dropped, oOverflow[c] is set, and existing entries are untouched.
- Pop on a full FIFO in the same cycle as an event: the write is accepted and no overflow is flagged.
- Read: oTimestamp/oEdge show the FIFO head of iRdCh combinationally. iRdEn pops at the next edge. iRdEn on an empty channel is ignored. An out-of-range iRdCh reads as empty.
- oOverflow[c] clears only on iClear or reset.
- iClear: empties all FIFOs and clears overflow and the counter. The synchronisers and arming state are kept. An event firing in the same cycle as iClear is dropped and does not set overflow.
- Mode change: a new iEdgeSel value applies to edges detected from the next cycle. Switching a channel off does not flush its FIFO.
- Reset: counter, FIFOs, pointers, synchronisers, arming and flags are all 0. All outputs read 0.

## Timing
- If iEvent[c] is first sampled high at edge k (s1 goes to 1):
  - the stored timestamp is the oCounter value held after edge k+1;
  - the entry is written at edge k+2;
  - oValid[c] rises after edge k+2.
- Pulses shorter than one iCLK period may be missed. Events closer than 2 cycles apart on one channel merge per the synchroniser.
- Pop: oValid, oTimestamp and oEdge update after the edge that samples iRdEn=1. Zero-bubble back-to-back pops are supported.
- iClear takes effect at the edge that samples it; the counter reads 0 in the following cycle.

## Test plan
- Counter and wrap: pWIDTH=8, release reset, run 260 cycles. Expect oCounter 0..255, then 0, with oWrap high exactly in the wrap cycle.
- Single capture: channel 0 in rising mode; raise iEvent[0] so s1 samples it at the edge where oCounter becomes 100. Expect oValid[0] 2 edges later, oTimestamp=101, oEdge=1. After a pop, oValid[0]=0 and oTimestamp=0.
- Both-edge mode and simultaneous channels: channels 0 and 1 in mode 11, driven by the same pulse. Expect 2 entries per channel with equal timestamps, edges 1 then 0, and a timestamp difference equal to the pulse width in cycles.
- Overflow: pDEPTH=4, 5 rising events on channel 2 with no reads. Expect 4 entries, oOverflow[2]=1, and the first 4 timestamps intact. A sixth event coincident with a pop on the full FIFO is accepted.
- Clear and reset corner cases:
  - iClear coincident with an event: FIFO empty, no overflow.
  - iEvent held high through reset release: no entry.
  - iRST_N pulsed low mid-capture: all outputs 0 asynchronously.
- Disabled mode and empty read: channel 3 in mode 00 with toggling input gives no entries. iRdEn on an empty channel leaves all state unchanged.

Source files
------------

// File: rtl/timestamp_capture.sv
// timestamp_capture: multi-channel event timestamper.
// A free-running counter is sampled when an enabled edge is seen on a
// synchronised event line. Each capture {edge type, timestamp} is queued in
// a per-channel FIFO and read back through a shared channel-select port.
module timestamp_capture #(
    parameter int pWIDTH    = 40,
    parameter int pCHANNELS = 4,
    parameter int pDEPTH    = 4,
    localparam int pRDW     = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [pCHANNELS-1:0]   iEvent,
    input  logic [2*pCHANNELS-1:0] iEdgeSel,
    input  logic                   iClear,
    input  logic [pRDW-1:0]        iRdCh,
    input  logic                   iRdEn,
    output logic [pWIDTH-1:0]      oTimestamp,
    output logic                   oEdge,
    output logic [pCHANNELS-1:0]   oValid,
    output logic [pCHANNELS-1:0]   oOverflow,
    output logic [pWIDTH-1:0]      oCounter,
    output logic                   oWrap
);

    localparam int pAW = $clog2(pDEPTH);

    logic [pWIDTH-1:0]      r_counter;
    logic                   r_wrap;
    logic [pCHANNELS-1:0]   r_s1, r_s2, r_s3;
    logic [2*pCHANNELS-1:0] r_edge_sel;
    logic [1:0]             r_arm_cnt;
    logic [pCHANNELS-1:0]   r_overflow;
    logic [pAW:0]           r_wr_ptr [pCHANNELS];
    logic [pAW:0]           r_rd_ptr [pCHANNELS];
    logic [pWIDTH:0]        r_mem    [pCHANNELS][pDEPTH];

    logic                   w_armed;
    logic [pCHANNELS-1:0]   w_rise, w_fall, w_fire;
    logic [pCHANNELS-1:0]   w_empty, w_full, w_pop, w_push, w_drop;
    logic [pWIDTH:0]        w_head;
    logic                   w_head_valid;

    // Free-running counter with a one-cycle pulse on the cycle showing 0 after a wrap.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_counter <= '0;
            r_wrap    <= 1'b0;
        end else if (iClear) begin
            r_counter <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_counter <= r_counter + 1'b1;
            r_wrap    <= (r_counter == '1);
        end
    end

    // Synchronisers, registered mode selection and post-reset arming; kept across iClear.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_edge_sel <= '0;
            r_arm_cnt  <= '0;
        end else begin
            r_s1       <= iEvent;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_edge_sel <= iEdgeSel;
            if (r_arm_cnt != 2'd3) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
        end
    end

    // Armed once three edges have passed since reset, so a line held high never fires.
    assign w_armed = (r_arm_cnt == 2'd3);

    // Per-channel edge detection, FIFO status and push/pop/drop decisions.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_rise = r_s2 & ~r_s3;
        w_fall = ~r_s2 & r_s3;
        w_fire = '0;
        w_empty = '0;
        w_full = '0;
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int c = 0; c < pCHANNELS; c++) begin
            w_fire[c]  = w_armed & ((w_rise[c] & r_edge_sel[2*c]) |
                                    (w_fall[c] & r_edge_sel[2*c+1]));
            w_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
            w_full[c]  = (r_wr_ptr[c][pAW] != r_rd_ptr[c][pAW]) &&
                         (r_wr_ptr[c][pAW-1:0] == r_rd_ptr[c][pAW-1:0]);
            w_pop[c]   = iRdEn & (iRdCh == pRDW'(c)) & ~w_empty[c] & ~iClear;
            // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
            w_push[c]  = w_fire[c] & ~iClear & (~w_full[c] | w_pop[c]);
            w_drop[c]  = w_fire[c] & ~iClear & w_full[c] & ~w_pop[c];
        end
    end

    // FIFO pointers and sticky overflow flags.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_overflow <= '0;
            for (int c = 0; c < pCHANNELS; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
            end
        end else if (iClear) begin
            r_overflow <= '0;
            for (int c = 0; c < pCHANNELS; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
            end
        end else begin
            r_overflow <= r_overflow | w_drop;
            for (int c = 0; c < pCHANNELS; c++) begin
                if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
            end
        end
    end

    // FIFO storage: entry is {edge type, timestamp}.
    // NOTE: storage has no reset; empty pointers make stale contents unobservable.
    always_ff @(posedge iCLK) begin
        for (int c = 0; c < pCHANNELS; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wr_ptr[c][pAW-1:0]] <= {w_rise[c], r_counter};
            end
        end
    end

    // Head of the selected channel; an out-of-range selection matches nothing and reads empty.
    always_comb begin
        w_head       = '0;
        w_head_valid = 1'b0;
        for (int c = 0; c < pCHANNELS; c++) begin
            if (iRdCh == pRDW'(c)) begin
                w_head_valid = ~w_empty[c];
                w_head       = r_mem[c][r_rd_ptr[c][pAW-1:0]];
            end
        end
    end

    assign oTimestamp = w_head_valid ? w_head[pWIDTH-1:0] : '0;
    assign oEdge      = w_head_valid & w_head[pWIDTH];
    assign oValid     = ~w_empty;
    assign oOverflow  = r_overflow;
    assign oCounter   = r_counter;
    assign oWrap      = r_wrap;

endmodule
